// File: rtl/nonce_tx_pkg.sv
// Shared types and framing constants for the nonce UART transmitter.
package nonce_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int DATA_BITS      = 8;
   localparam int FRAME_BITS     = 10;

endpackage

// File: rtl/nonce_transmit_if.sv
// Push-side bundle between the nonce checker and the transmitter.
interface nonce_transmit_if;
   // Handshake: nonce_valid is a one-cycle push strobe qualified by nonce; full
   // is the backpressure flag seen in the same cycle, and a push made while full
   // is dropped and reported by a one-cycle overflow pulse on the next cycle.
   logic [31:0] nonce;
   logic        nonce_valid;
   logic        full;
   logic        overflow;
   logic        busy;

   modport master (
      output nonce,
      output nonce_valid,
      input  full,
      input  overflow,
      input  busy
   );

   modport slave (
      input  nonce,
      input  nonce_valid,
      output full,
      output overflow,
      output busy
   );
endinterface

// File: rtl/nonce_fifo.sv
// Synchronous word FIFO with wrap-bit pointers and registered full/empty flags.
module nonce_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push;
   logic             do_pop;

   // Flags come from the current registers, so a pop never opens room for a push in the same cycle.
   assign do_push = push & ~full_q;
   assign do_pop  = pop & ~empty_q;

   always_comb begin
      wr_d    = wr_q + (AW+1)'(do_push);
      rd_d    = rd_q + (AW+1)'(do_pop);
      full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
      empty_d = (wr_d == rd_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q[AW-1:0]] <= din;
      end
   end

   assign dout  = mem_q[rd_q[AW-1:0]];
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/nonce_transmit.sv
// Golden-nonce transmitter: FIFO-buffered 32-bit words sent LSB byte first as 8N1 UART.
// Optional NONCE_TX_DEDUP_EN discards a push equal to the last accepted nonce.
module nonce_transmit
   import nonce_tx_pkg::*;
#(
   parameter int BAUD_DIV   = 434,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   nonce_transmit_if.slave  nif,
   output logic             TxD,
   output tx_state_t        state_dbg
);

   localparam int BW = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic [1:0]    BYTE_LAST = 2'(BYTES_PER_WORD - 1);

   tx_state_t   state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [1:0]  byte_q, byte_d;
   logic [31:0] shift_q, shift_d;
   logic        txd_q, txd_d;
   logic        ovf_q, ovf_d;

   logic        push, pop;
   logic        fifo_full, fifo_empty;
   logic [31:0] fifo_dout;
   logic        bit_end;
   logic        dup;
   logic [2:0]  bit_nxt;
   logic [7:0]  cur_byte;

`ifdef NONCE_TX_DEDUP_EN
   logic [31:0] last_q, last_d;

   assign dup    = (nif.nonce == last_q);
   assign last_d = push ? nif.nonce : last_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= '0;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // A duplicate is swallowed quietly even when the FIFO is full.
   assign push  = nif.nonce_valid & ~fifo_full & ~dup;
   assign ovf_d = nif.nonce_valid & fifo_full & ~dup;
   assign pop   = (state_q == LOAD);

   nonce_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (nif.nonce),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign bit_end  = (baud_q == BAUD_LAST);
   assign bit_nxt  = bit_q + 3'd1;
   assign cur_byte = shift_q[7:0];

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            txd_d  = 1'b1;
            if (!fifo_empty) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            shift_d = fifo_dout;
            byte_d  = '0;
            bit_d   = '0;
            baud_d  = '0;
            txd_d   = 1'b0;
            state_d = START;
         end
         START: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               txd_d   = cur_byte[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
                  txd_d   = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_d = bit_nxt;
                  txd_d = cur_byte[bit_nxt];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (byte_q != BYTE_LAST) begin
                  byte_d  = byte_q + 2'd1;
                  shift_d = shift_q >> DATA_BITS;
                  txd_d   = 1'b0;
                  state_d = START;
               end else if (!fifo_empty) begin
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   // Reset drives the line high immediately, abandoning any partial frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign TxD          = txd_q;
   assign state_dbg    = state_q;
   assign nif.full     = fifo_full;
   assign nif.overflow = ovf_q;
   assign nif.busy     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_nonce_transmit.sv
// Directed bench for nonce_transmit: a UART monitor decodes TxD against an expected byte queue.
module tb_nonce_transmit;
   import nonce_tx_pkg::*;

   localparam int BAUD_DIV   = 4;
   localparam int FIFO_DEPTH = 4;

   logic      clk = 1'b0;
   logic      reset_n = 1'b0;
   logic      TxD;
   tx_state_t state_dbg;

   nonce_transmit_if nif();

   nonce_transmit #(
      .BAUD_DIV   (BAUD_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .nif       (nif),
      .TxD       (TxD),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state
   int         checks = 0;
   int         errors = 0;
   int         ovf_cnt = 0;
   int         frame_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         start_q[$];
   int         p, k, at, n_exp;

   always @(negedge clk) if (nif.overflow === 1'b1) ovf_cnt++;

   // UART monitor: samples each bit in its middle; a reset inside a frame discards that byte.
   initial begin : uart_mon
      logic [7:0] sh;
      logic       ok;
      int         s;
      int         n;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && TxD === 1'b0) begin
            s  = cyc;
            ok = 1'b1;
            sh = '0;
            for (int b = 0; b < FRAME_BITS; b++) begin
               n = (b == 0) ? BAUD_DIV / 2 : BAUD_DIV;
               for (int j = 0; j < n; j++) begin
                  @(negedge clk);
                  if (reset_n !== 1'b1) ok = 1'b0;
               end
               if (!ok) break;
               if (b == 0 && TxD !== 1'b0) begin
                  frame_err++;
                  ok = 1'b0;
                  break;
               end
               if (b >= 1 && b <= DATA_BITS) sh[b-1] = TxD;
               if (b == FRAME_BITS - 1 && TxD !== 1'b1) frame_err++;
            end
            if (ok) begin
               rx_q.push_back(sh);
               start_q.push_back(s);
            end
         end
      end
   end

   // ---------------- driver / checker tasks
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic [31:0] v);
      nif.nonce       = v;
      nif.nonce_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      nif.nonce_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_word(input logic [31:0] v);
      for (int i = 0; i < BYTES_PER_WORD; i++) exp_q.push_back(v[8*i +: 8]);
   endtask

   task automatic wait_bytes(input string tag, input int n, input int budget);
      int c;
      c = 0;
      while (rx_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      check(tag, 32'(rx_q.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input string tag, output int when, input int budget);
      int c;
      c = 0;
      while (nif.busy !== 1'b0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      when = cyc;
      check(tag, 32'(nif.busy), 32'd0);
   endtask

   task automatic compare_bytes(input string tag);
      logic [7:0] e, r;
      check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         r = rx_q.pop_front();
         check(tag, 32'(r), 32'(e));
      end
      exp_q.delete();
      rx_q.delete();
      start_q.delete();
   endtask

   // ---------------- directed sequence
   initial begin
      nif.nonce       = '0;
      nif.nonce_valid = 1'b0;
      repeat (2) @(negedge clk);

      check("rst_txd", 32'(TxD), 32'd1);
      check("rst_full", 32'(nif.full), 32'd0);
      check("rst_overflow", 32'(nif.overflow), 32'd0);
      check("rst_busy", 32'(nif.busy), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      reset_n = 1'b1;
      idle(2);

      // Basic frame: LOAD one cycle after the push, start bit two cycles after,
      // busy drops 160 cycles after the LOAD cycle ends.
      drive(32'h12345678);
      p = cyc;
      expect_word(32'h12345678);
      idle(1);
      check("t1_load", 32'(state_dbg), 32'(LOAD));
      check("t1_busy", 32'(nif.busy), 32'd1);
      wait_bytes("t1_rx_timeout", 4, 300);
      check("t1_start_cycle", 32'(start_q[0]), 32'(p + 2));
      check("t1_byte_spacing", 32'(start_q[1] - start_q[0]), 32'(10 * BAUD_DIV));
      wait_idle("t1_idle_timeout", at, 300);
      check("t1_busy_fall", 32'(at), 32'(p + 162));
      compare_bytes("t1_byte");

      // Back-to-back words: 40-cycle byte pitch inside a word, 41 across words.
      drive(32'hDEADBEEF);
      drive(32'h00000001);
      drive(32'hFFFFFFFF);
      idle(0);
      expect_word(32'hDEADBEEF);
      expect_word(32'h00000001);
      expect_word(32'hFFFFFFFF);
      wait_bytes("t2_rx_timeout", 12, 800);
      check("t2_pitch_in_word", 32'(start_q[3] - start_q[2]), 32'(10 * BAUD_DIV));
      check("t2_gap_word1", 32'(start_q[4] - start_q[3]), 32'(10 * BAUD_DIV + 1));
      check("t2_gap_word2", 32'(start_q[8] - start_q[7]), 32'(10 * BAUD_DIV + 1));
      wait_idle("t2_idle_timeout", at, 300);
      compare_bytes("t2_byte");
      check("t2_no_overflow", 32'(ovf_cnt), 32'd0);

      // Overflow: one word in flight plus four queued fills the FIFO.
      drive(32'hA0000001);
      expect_word(32'hA0000001);
      idle(3);
      drive(32'hA0000002);
      drive(32'hA0000003);
      drive(32'hA0000004);
      check("t3_full_at_3", 32'(nif.full), 32'd0);
      drive(32'hA0000005);
      check("t3_full_at_4", 32'(nif.full), 32'd1);
      drive(32'hA0000006);
      check("t3_ovf_pulse", 32'(nif.overflow), 32'd1);
      check("t3_full_hold", 32'(nif.full), 32'd1);
      idle(1);
      check("t3_ovf_clear", 32'(nif.overflow), 32'd0);
      expect_word(32'hA0000002);
      expect_word(32'hA0000003);
      expect_word(32'hA0000004);
      expect_word(32'hA0000005);

      // Push while full in the same cycle as the LOAD pop: dropped.
      k = 0;
      while (state_dbg !== LOAD && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("t4_load_seen", 32'(state_dbg), 32'(LOAD));
      drive(32'hA0000007);
      check("t4_ovf_pulse", 32'(nif.overflow), 32'd1);
      check("t4_full_after_pop", 32'(nif.full), 32'd0);
      idle(1);
      check("t4_ovf_clear", 32'(nif.overflow), 32'd0);
      wait_bytes("t34_rx_timeout", 20, 1200);
      wait_idle("t34_idle_timeout", at, 300);
      idle(20);
      compare_bytes("t34_byte");
      check("t34_ovf_count", 32'(ovf_cnt), 32'd2);

      // Reset during DATA bit 3 of byte 2 (0xF0 -> bit 3 is 0), with a word still queued.
      drive(32'h00F00000);
      p = cyc;
      drive(32'h77777777);
      idle(0);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      while (cyc < p + 99) @(negedge clk);
      check("t5_pre_bit3", 32'(TxD), 32'd0);
      check("t5_pre_busy", 32'(nif.busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("t5_txd_async", 32'(TxD), 32'd1);
      check("t5_busy_rst", 32'(nif.busy), 32'd0);
      check("t5_state_rst", 32'(state_dbg), 32'(IDLE));
      idle(3);
      reset_n = 1'b1;
      idle(6);
      check("t5_fifo_discarded", 32'(nif.busy), 32'd0);
      check("t5_state_idle", 32'(state_dbg), 32'(IDLE));
      compare_bytes("t5_partial");
      drive(32'hA5A5A5A5);
      p = cyc;
      idle(0);
      expect_word(32'hA5A5A5A5);
      wait_bytes("t5_rx_timeout", 4, 300);
      check("t5_start_cycle", 32'(start_q[0]), 32'(p + 2));
      wait_idle("t5_idle_timeout", at, 300);
      compare_bytes("t5_byte");

      // Repeated value: dropped only when deduplication is built in.
      drive(32'h55AA55AA);
      drive(32'h55AA55AA);
      drive(32'h11111111);
      idle(0);
      expect_word(32'h55AA55AA);
`ifdef NONCE_TX_DEDUP_EN
      n_exp = 8;
`else
      expect_word(32'h55AA55AA);
      n_exp = 12;
`endif
      expect_word(32'h11111111);
      wait_bytes("t6_rx_timeout", n_exp, 800);
      wait_idle("t6_idle_timeout", at, 300);
      idle(60);
      compare_bytes("t6_byte");
      check("t6_no_overflow", 32'(ovf_cnt), 32'd2);

      check("frame_errors", 32'(frame_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nonce_transmit.md
# nonce_transmit

Miner-side transmitter for golden nonces, the sending end of the hub's per-slave nonce receiver. Accepts 32-bit nonces from the hashing core, buffers them in a small FIFO, and serialises each as four 8N1 UART bytes on `TxD` toward the hub. It sits between the miner's nonce-check logic and the hub link, and it never drops a word silently.

## Interface
- `BAUD_DIV`, 434: clock cycles per UART bit, minimum 2. The default gives 115200 baud at 50 MHz.
- `FIFO_DEPTH`, 4: nonce buffer entries, a power of two, minimum 2.
- `clk`  in  1  single clock; every register is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `nonce`  in  32  golden nonce value.
- `nonce_valid`  in  1  one-cycle push strobe for `nonce`.
- `full`  out  1  the FIFO holds `FIFO_DEPTH` entries.
- `overflow`  out  1  one-cycle pulse when a push is dropped.
- `busy`  out  1  a frame is in progress or the FIFO is non-empty.
- `TxD`  out  1  serial line, idle high.

## Operation
- Reset state: `TxD`=1, `full`=0, `overflow`=0, `busy`=0, FIFO empty, state IDLE, all counters 0.
- Push:
  - When `nonce_valid`=1 and the FIFO is not full, the word is written at that edge.
  - `full` is evaluated before any pop in the same cycle. A push while full is dropped and raises `overflow` on the next cycle.
- Word format: 4 bytes, least-significant byte first (`nonce[7:0]` first). Each byte is sent as a start bit (0), 8 data bits LSB first, then a stop bit (1).
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE -> LOAD when the FIFO is non-empty.
  - LOAD pops the head into a 32-bit shift word, sets byte_cnt=0, then goes to START.
  - START drives 0 for one bit period, then goes to DATA.
  - DATA drives one bit per bit period, with bit_cnt running 0..7. After bit 7 it goes to STOP.
  - STOP drives 1 for one bit period. Then:
    - if byte_cnt<3: byte_cnt+1, shift word right by 8, go to START;
    - otherwise go to LOAD if the FIFO is non-empty, else IDLE.
- Counters:
  - baud_cnt runs 0..`BAUD_DIV`-1 with width clog2(`BAUD_DIV`). It wraps at bit end.
  - bit_cnt is 3 bits, byte_cnt is 2 bits.
- FIFO pointers are clog2(`FIFO_DEPTH`)+1 bits wide and wrap modulo 2×depth. Full means the MSBs differ and the rest match. Empty means the pointers are equal.
- Simultaneous push and pop:
  - when not full, both take effect and the count is unchanged;
  - when full, the push is dropped even though the pop frees a slot.
- `busy` = (state≠IDLE) or FIFO non-empty.
- If `reset_n` is asserted mid-frame, `TxD` goes high immediately (asynchronously), the partial frame is abandoned and FIFO contents are discarded. After release the block restarts from IDLE.

## Timing
- A push at edge N with an empty FIFO and IDLE state gives LOAD at N+1 and the start bit on `TxD` from N+2.
- Each bit lasts exactly `BAUD_DIV` cycles. One byte takes 10×`BAUD_DIV` cycles and one word takes 40×`BAUD_DIV`.
- There is no idle gap between bytes of a word. Between queued words the gap is exactly one cycle (the LOAD state).
- `TxD` is driven from a register and is glitch-free.
- `full` and `overflow` are registered.

## Configuration
- `NONCE_TX_DEDUP_EN` defined:
  - a push whose value equals the most recently accepted nonce is discarded silently: no write, no `overflow`;
  - the last-accepted register resets to 0, so a first push of 0 is discarded.
- `NONCE_TX_DEDUP_EN` undefined: every non-full push is queued, and the comparator and register are absent.

## Structure
- Package `nonce_tx_pkg` holds:
  - the FSM state enum (IDLE, LOAD, START, DATA, STOP);
  - `BYTES_PER_WORD`=4;
  - `DATA_BITS`=8;
  - `FRAME_BITS`=10.
- Sub-module `nonce_fifo` is a synchronous FIFO, 32-bit by `FIFO_DEPTH`, with `push`, `pop`, `din`, `dout`, `full` and `empty`, using the same clock and reset. The FSM, baud counter and dedup logic stay in `nonce_transmit`.

## Test plan
- Basic frame, with `BAUD_DIV`=4:
  - stimulus: push 0x12345678;
  - response: the bench UART decodes bytes 0x78, 0x56, 0x34, 0x12; the start bit is first seen at push+2 cycles; `busy` falls 160 cycles after LOAD.
- Back-to-back:
  - stimulus: push 0xDEADBEEF, 0x00000001, 0xFFFFFFFF on consecutive cycles;
  - response: 12 bytes arrive in order, with a 1-cycle gap between words and `overflow` never set.
- Overflow, with `FIFO_DEPTH`=4:
  - stimulus: push 6 distinct words while the first frame is in progress;
  - response: `full` is asserted after the 5th push accepted (1 in flight + 4 queued); the 6th raises `overflow` for 1 cycle; 5 words are transmitted.
- Push on a full FIFO in the same cycle as a pop:
  - response: the push is dropped, `overflow` pulses once, and the popped word is still transmitted.
- Reset mid-frame:
  - stimulus: assert `reset_n`=0 during DATA bit 3 of byte 2;
  - response: `TxD`=1 within the same cycle, the FIFO is empty, and after release a new push 0xA5A5A5A5 transmits cleanly.
- Dedup, with `NONCE_TX_DEDUP_EN` defined:
  - stimulus: push 0x55AA55AA twice, then 0x11111111;
  - response: 2 words are transmitted and `overflow` stays 0.
  - Without the macro, the same stimulus transmits 3 words.
